// File: rtl/mmcm_drp_pkg.sv
// Shared types, DRP address map and divider encoding for MMCM output reprogramming.
package mmcm_drp_pkg;

  localparam int unsigned DRP_AW  = 7;
  localparam int unsigned DRP_DW  = 16;
  localparam int unsigned MAX_DIV = 128;

  // Bits of each register preserved across a read-modify-write (1 = keep)
  localparam logic [DRP_DW-1:0] REG1_KEEP     = 16'hF000;
  localparam logic [DRP_DW-1:0] REG2_KEEP     = 16'hFF3F;
  localparam logic [DRP_DW-1:0] REG2_KEEP_CH0 = 16'hF73F;

  typedef enum logic [3:0] {
    ST_RST_OFF,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_CHECK,
    ST_RST_ON,
    ST_RD1,
    ST_WR1,
    ST_RD2,
    ST_WR2
  } state_t;

  typedef enum logic [1:0] {
    RMW_IDLE,
    RMW_RD,
    RMW_WR
  } rmw_state_t;

  typedef struct packed {
    logic [5:0] hi;
    logic [5:0] lo;
    logic       edge_b;
    logic       nocount;
  } div_regs_t;

  // Counter high/low split; divide-by-1 bypasses the counter entirely
  function automatic div_regs_t div_to_regs(input logic [7:0] div);
    div_regs_t r;
    r.hi      = 6'(div >> 1);
    r.lo      = 6'(div - (div >> 1));
    r.edge_b  = div[0];
    r.nocount = (div == 8'd1);
    if (div == 8'd1) begin
      r.hi     = '0;
      r.lo     = '0;
      r.edge_b = 1'b0;
    end
    return r;
  endfunction

  // ClkReg1 address per CLKOUTn; ClkReg2 is always the next address
  function automatic logic [DRP_AW-1:0] reg1_addr(input logic [2:0] chan);
    logic [DRP_AW-1:0] a;
    case (chan)
      3'd0:    a = 7'h08;
      3'd1:    a = 7'h0A;
      3'd2:    a = 7'h0C;
      3'd3:    a = 7'h0E;
      3'd4:    a = 7'h10;
      3'd5:    a = 7'h06;
      default: a = 7'h12;
    endcase
    return a;
  endfunction

  function automatic logic [DRP_DW-1:0] reg1_word(input div_regs_t r);
    return {4'h0, r.hi, r.lo};
  endfunction

  function automatic logic [DRP_DW-1:0] reg2_word(input div_regs_t r);
    return {8'h00, r.edge_b, r.nocount, 6'h00};
  endfunction

endpackage

// File: rtl/mmcm_drp_rmw.sv
// One DRP read-modify-write: read, merge kept bits with new data, write back.
module mmcm_drp_rmw
  import mmcm_drp_pkg::*;
#(
  parameter int unsigned DRP_TIMEOUT = 64
) (
  input  logic              clk_in0,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [DRP_AW-1:0] i_addr,
  input  logic [DRP_DW-1:0] i_mask,
  input  logic [DRP_DW-1:0] i_data,
  output logic              o_rd_done,
  output logic              o_done,
  output logic              o_err,
  output logic [DRP_AW-1:0] o_daddr,
  output logic [DRP_DW-1:0] o_di,
  output logic              o_den,
  output logic              o_dwe,
  input  logic [DRP_DW-1:0] i_do,
  input  logic              i_drdy
);

  localparam int unsigned TW = $clog2(DRP_TIMEOUT + 1);

  rmw_state_t        r_st, w_st_nxt;
  logic [TW-1:0]     r_cnt, w_cnt_nxt;
  logic [DRP_DW-1:0] r_mask, w_mask_nxt, r_data, w_data_nxt;
  logic [DRP_AW-1:0] r_daddr, w_daddr_nxt;
  logic [DRP_DW-1:0] r_di, w_di_nxt;
  logic              r_den, w_den_nxt, r_dwe, w_dwe_nxt;
  logic              r_rd_done, w_rd_done_nxt, r_done, w_done_nxt, r_err, w_err_nxt;

  // State and registered DRP/status outputs
  always_ff @(posedge clk_in0 or negedge reset_n) begin
    if (!reset_n) begin
      r_st      <= RMW_IDLE;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_data    <= '0;
      r_daddr   <= '0;
      r_di      <= '0;
      r_den     <= 1'b0;
      r_dwe     <= 1'b0;
      r_rd_done <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mask    <= w_mask_nxt;
      r_data    <= w_data_nxt;
      r_daddr   <= w_daddr_nxt;
      r_di      <= w_di_nxt;
      r_den     <= w_den_nxt;
      r_dwe     <= w_dwe_nxt;
      r_rd_done <= w_rd_done_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Access sequencing; drdy outside an access is ignored
  always_comb begin
    w_st_nxt      = r_st;
    w_cnt_nxt     = r_cnt;
    w_mask_nxt    = r_mask;
    w_data_nxt    = r_data;
    w_daddr_nxt   = r_daddr;
    w_di_nxt      = r_di;
    w_den_nxt     = 1'b0;
    w_dwe_nxt     = 1'b0;
    w_rd_done_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_st)
      RMW_IDLE: begin
        if (i_start) begin
          w_st_nxt    = RMW_RD;
          w_cnt_nxt   = '0;
          w_daddr_nxt = i_addr;
          w_mask_nxt  = i_mask;
          w_data_nxt  = i_data;
          w_den_nxt   = 1'b1;
        end
      end
      RMW_RD: begin
        if (i_drdy) begin
          w_st_nxt      = RMW_WR;
          w_cnt_nxt     = '0;
          w_di_nxt      = (i_do & r_mask) | (r_data & ~r_mask);
          w_den_nxt     = 1'b1;
          w_dwe_nxt     = 1'b1;
          w_rd_done_nxt = 1'b1;
        end else if (r_cnt == TW'(DRP_TIMEOUT)) begin
          w_st_nxt  = RMW_IDLE;
          w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end
      RMW_WR: begin
        if (i_drdy) begin
          w_st_nxt   = RMW_IDLE;
          w_done_nxt = 1'b1;
        end else if (r_cnt == TW'(DRP_TIMEOUT)) begin
          w_st_nxt  = RMW_IDLE;
          w_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end
      default: w_st_nxt = RMW_IDLE;
    endcase
  end

  assign o_daddr   = r_daddr;
  assign o_di      = r_di;
  assign o_den     = r_den;
  assign o_dwe     = r_dwe;
  assign o_rd_done = r_rd_done;
  assign o_done    = r_done;
  assign o_err     = r_err;

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// Runtime CLKOUTn divider reprogramming for an MMCM via DRP with reset/relock handling.
module mmcm_drp_reconfig
  import mmcm_drp_pkg::*;
#(
  parameter  int unsigned NUM_CLKOUT   = 5,
  parameter  int unsigned DIV_W        = 8,
  parameter  int unsigned DRP_TIMEOUT  = 64,
  parameter  int unsigned LOCK_TIMEOUT = 65535,
  localparam int unsigned CW           = (NUM_CLKOUT > 1) ? $clog2(NUM_CLKOUT) : 1
) (
  input  logic              clk_in0,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CW-1:0]     req_chan,
  input  logic [DIV_W-1:0]  req_div,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DRP_AW-1:0] drp_daddr,
  output logic [DRP_DW-1:0] drp_di,
  input  logic [DRP_DW-1:0] drp_do,
  output logic              drp_den,
  output logic              drp_dwe,
  input  logic              drp_drdy,
  output logic              mmcm_rst,
  input  logic              mmcm_locked
);

  localparam int unsigned LCW = $clog2(LOCK_TIMEOUT + 1);

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_chan, w_chan_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [LCW-1:0]    r_lcnt, w_lcnt_nxt;
  logic              r_pass_ok, w_pass_ok_nxt;
  logic              r_mmcm_rst, w_mmcm_rst_nxt;
  logic              r_busy, r_req_ready, r_done, w_done_nxt, r_err, w_err_nxt;
  logic              r_lock_meta, r_lock_sync;
  logic              w_rmw_start, w_rmw_rd_done, w_rmw_done, w_rmw_err;
  logic              w_illegal, w_sel2;
  div_regs_t         w_regs;
  logic [DRP_AW-1:0] w_rmw_addr;
  logic [DRP_DW-1:0] w_rmw_mask, w_rmw_data;

  // Two-flop synchroniser for LOCKED
  always_ff @(posedge clk_in0 or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= mmcm_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  assign w_illegal = (r_div == '0) || (32'(r_div) > MAX_DIV) || (32'(r_chan) >= NUM_CLKOUT);
  assign w_regs    = div_to_regs(8'(r_div));
  assign w_sel2    = (r_state == ST_WR1);
  assign w_rmw_addr = w_sel2 ? reg1_addr(3'(r_chan)) + 7'd1 : reg1_addr(3'(r_chan));
  assign w_rmw_mask = w_sel2 ? ((r_chan == '0) ? REG2_KEEP_CH0 : REG2_KEEP) : REG1_KEEP;
  assign w_rmw_data = w_sel2 ? reg2_word(w_regs) : reg1_word(w_regs);

  // Top state register and registered control outputs
  always_ff @(posedge clk_in0 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RST_OFF;
      r_chan      <= '0;
      r_div       <= '0;
      r_lcnt      <= '0;
      r_pass_ok   <= 1'b0;
      r_mmcm_rst  <= 1'b1;
      r_busy      <= 1'b1;
      r_req_ready <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_chan      <= w_chan_nxt;
      r_div       <= w_div_nxt;
      r_lcnt      <= w_lcnt_nxt;
      r_pass_ok   <= w_pass_ok_nxt;
      r_mmcm_rst  <= w_mmcm_rst_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Request sequencing: check, hold reset, two RMWs, release, await lock
  always_comb begin
    w_state_nxt    = r_state;
    w_chan_nxt     = r_chan;
    w_div_nxt      = r_div;
    w_lcnt_nxt     = r_lcnt;
    w_pass_ok_nxt  = r_pass_ok;
    w_mmcm_rst_nxt = r_mmcm_rst;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_rmw_start    = 1'b0;
    case (r_state)
      ST_RST_OFF: begin
        w_mmcm_rst_nxt = 1'b0;
        w_lcnt_nxt     = '0;
        w_state_nxt    = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (r_lock_sync) begin
          w_done_nxt    = r_pass_ok;
          w_pass_ok_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else if (r_lcnt == LCW'(LOCK_TIMEOUT)) begin
          w_err_nxt     = 1'b1;
          w_pass_ok_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_lcnt_nxt = r_lcnt + LCW'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_chan_nxt  = req_chan;
          w_div_nxt   = req_div;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_illegal) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_pass_ok_nxt = 1'b1;
          w_state_nxt   = ST_RST_ON;
        end
      end
      ST_RST_ON: begin
        w_mmcm_rst_nxt = 1'b1;
        w_rmw_start    = 1'b1;
        w_state_nxt    = ST_RD1;
      end
      ST_RD1, ST_RD2: begin
        if (w_rmw_err) begin
          w_err_nxt     = 1'b1;
          w_pass_ok_nxt = 1'b0;
          w_state_nxt   = ST_RST_OFF;
        end else if (w_rmw_rd_done) begin
          w_state_nxt = (r_state == ST_RD1) ? ST_WR1 : ST_WR2;
        end
      end
      ST_WR1, ST_WR2: begin
        if (w_rmw_err) begin
          w_err_nxt     = 1'b1;
          w_pass_ok_nxt = 1'b0;
          w_state_nxt   = ST_RST_OFF;
        end else if (w_rmw_done) begin
          w_rmw_start = (r_state == ST_WR1);
          w_state_nxt = (r_state == ST_WR1) ? ST_RD2 : ST_RST_OFF;
        end
      end
      default: w_state_nxt = ST_RST_OFF;
    endcase
  end

  mmcm_drp_rmw #(
    .DRP_TIMEOUT(DRP_TIMEOUT)
  ) u_rmw (
    .clk_in0  (clk_in0),
    .reset_n  (reset_n),
    .i_start  (w_rmw_start),
    .i_addr   (w_rmw_addr),
    .i_mask   (w_rmw_mask),
    .i_data   (w_rmw_data),
    .o_rd_done(w_rmw_rd_done),
    .o_done   (w_rmw_done),
    .o_err    (w_rmw_err),
    .o_daddr  (drp_daddr),
    .o_di     (drp_di),
    .o_den    (drp_den),
    .o_dwe    (drp_dwe),
    .i_do     (drp_do),
    .i_drdy   (drp_drdy)
  );

  assign mmcm_rst  = r_mmcm_rst;
  assign busy      = r_busy;
  assign req_ready = r_req_ready;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Scoreboard bench: DRP register-file model, lock model, request driver and output monitor.
module tb_mmcm_drp_reconfig;

  localparam int NCLK = 5;
  localparam int DT   = 64;
  localparam int LT   = 2000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_chan;
  logic [7:0]  req_div;
  logic        busy, done, err;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_den, drp_dwe, drp_drdy;
  logic        mmcm_rst, mmcm_locked;

  mmcm_drp_reconfig #(
    .NUM_CLKOUT(NCLK), .DIV_W(8), .DRP_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_in0(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_chan(req_chan), .req_div(req_div), .busy(busy), .done(done), .err(err),
    .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_do(drp_do), .drp_den(drp_den),
    .drp_dwe(drp_dwe), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    int          a1;
    int          a2;
    logic [15:0] v1;
    logic [15:0] v2;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [128];
  int errors = 0, checks = 0;
  int cyc = 0, done_cnt = 0, den_cnt = 0, rst_hi_cnt = 0;
  int acc_cnt = 0, pend = 0, rd2_cyc = 0, last_err_cyc = 0;
  int lock_delay = 100, lock_cnt = 0;
  bit lock_never = 0, withhold_rd2 = 0, spurious_req = 0, pend_wr = 0;
  logic [6:0]  pend_addr;
  logic [15:0] pend_di;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int chan_base(input int chan);
    case (chan)
      0: return 8;
      1: return 10;
      2: return 12;
      3: return 14;
      4: return 16;
      5: return 6;
      default: return 18;
    endcase
  endfunction

  // Reference result of a request, from the divider rules and current register contents
  function automatic exp_t model_req(input int chan, input int div);
    exp_t e;
    int hi, lo, edge_v, nc, a;
    e.is_err = 0; e.a1 = 0; e.a2 = 0; e.v1 = '0; e.v2 = '0;
    if (div < 1 || div > 128 || chan >= NCLK) begin
      e.is_err = 1;
      return e;
    end
    if (div == 1) begin
      hi = 0; lo = 0; edge_v = 0; nc = 1;
    end else begin
      hi = div / 2; lo = div - hi; edge_v = div % 2; nc = 0;
    end
    a = chan_base(chan);
    e.a1 = a;
    e.a2 = a + 1;
    e.v1 = (mem[a] & 16'hF000) | 16'((hi % 64) * 64 + (lo % 64));
    e.v2 = mem[a + 1] & 16'hFF3F;
    if (chan == 0) e.v2 = e.v2 & 16'hF7FF;
    e.v2 = e.v2 | 16'(edge_v * 128 + nc * 64);
    return e;
  endfunction

  // DRP slave: register file, drdy 1..10 cycles after den, optional withheld RD2
  initial begin
    drp_drdy = 1'b0;
    drp_do   = '0;
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (!reset_n) begin
        pend = 0;
      end else if (drp_den) begin
        den_cnt++;
        acc_cnt++;
        chk("den_while_pending", 32'(pend != 0), 32'd0);
        if (withhold_rd2 && acc_cnt == 3) begin
          withhold_rd2 = 0;
          rd2_cyc = cyc;
          pend = 0;
        end else begin
          pend      = int'($urandom_range(1, 10));
          pend_wr   = drp_dwe;
          pend_addr = drp_daddr;
          pend_di   = drp_di;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (pend_wr) mem[pend_addr] = pend_di;
          else drp_do = mem[pend_addr];
          drp_drdy = 1'b1;
        end
      end else if (spurious_req) begin
        spurious_req = 0;
        drp_do   = 16'($urandom);
        drp_drdy = 1'b1;
      end
    end
  end

  // LOCKED model: drops with RST, rises lock_delay cycles after release
  initial begin
    mmcm_locked = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && mmcm_rst) rst_hi_cnt++;
      if (!reset_n || mmcm_rst) begin
        mmcm_locked = 1'b0;
        lock_cnt = 0;
      end else if (!mmcm_locked && !lock_never) begin
        lock_cnt++;
        if (lock_cnt >= lock_delay) mmcm_locked = 1'b1;
      end
    end
  end

  // Monitor: every done/err pulse is matched against the scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (done || err)) begin
        chk("done_err_same_cycle", 32'(done && err), 32'd0);
        if (err) last_err_cyc = cyc;
        if (done) done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_done_err", {30'd0, done, err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind_err", 32'(err), 32'(e.is_err));
          if (done && !e.is_err) begin
            chk($sformatf("reg1_%0h", e.a1), 32'(mem[e.a1]), 32'(e.v1));
            chk($sformatf("reg2_%0h", e.a2), 32'(mem[e.a2]), 32'(e.v2));
          end
        end
      end
    end
  end

  task automatic wait_ready(input int maxc, input string nm);
    int n = 0;
    while (!req_ready && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(req_ready), 32'd1);
  endtask

  // mode 0: model expectation, 1: expect err, 2: expect nothing
  task automatic issue(input int chan, input int div, input int mode);
    exp_t e;
    wait_ready(LT + 500, "ready_before_req");
    if (mode == 0) begin
      e = model_req(chan, div);
      exp_q.push_back(e);
    end else if (mode == 1) begin
      e = model_req(7, 0);
      exp_q.push_back(e);
    end
    acc_cnt   = 0;
    req_chan  = 3'(chan);
    req_div   = 8'(div);
    req_valid = 1'b1;
    @(negedge clk);
    req_chan = 3'd6;
    req_div  = 8'd200;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mmcm_rst"}, 32'(mmcm_rst), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_den"}, 32'(drp_den), 32'd0);
    chk({tag, "_dwe"}, 32'(drp_dwe), 32'd0);
    chk({tag, "_daddr"}, 32'(drp_daddr), 32'd0);
    chk({tag, "_di"}, 32'(drp_di), 32'd0);
  endtask

  initial begin
    int d0, r0, rel, n;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_chan  = '0;
    req_div   = '0;
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    chk_reset_vals("por");

    // Initial lock pass: RST released on first clock, no done
    reset_n = 1'b1;
    @(negedge clk);
    chk("init_rst_released", 32'(mmcm_rst), 32'd0);
    chk("init_busy", 32'(busy), 32'd1);
    wait_ready(300, "init_ready");
    chk("init_busy_low", 32'(busy), 32'd0);
    chk("init_no_done", 32'(done_cnt), 32'd0);

    // Known-value reprogramming
    lock_delay = 20;
    mem[12] = 16'hF000;
    issue(2, 30, 0);
    wait_ready(1000, "ch2_ready");
    chk("ch2_reg1", 32'(mem[12]), 32'hF3CF);
    chk("ch2_reg2_76", 32'(mem[13][7:6]), 32'd0);
    chk("ch2_done_cnt", 32'(done_cnt), 32'd1);
    chk("ch2_busy_low", 32'(busy), 32'd0);

    issue(0, 1, 0);
    wait_ready(1000, "div1_ready");
    chk("div1_reg1", 32'(mem[8][11:0]), 32'h000);
    chk("div1_reg2_76", 32'(mem[9][7:6]), 32'd1);
    chk("div1_frac", 32'(mem[9][11]), 32'd0);
    issue(0, 7, 0);
    wait_ready(1000, "div7_ready");
    chk("div7_reg1", 32'(mem[8][11:0]), 32'h0C4);
    chk("div7_edge", 32'(mem[9][7]), 32'd1);
    issue(3, 128, 0);
    wait_ready(1000, "div128_ready");
    chk("div128_reg1", 32'(mem[14][11:0]), 32'h000);
    chk("div128_reg2_76", 32'(mem[15][7:6]), 32'd0);

    // Randomised requests, with occasional spurious drdy while idle
    for (int k = 0; k < 14; k++) begin
      lock_delay = int'($urandom_range(3, 60));
      wait_ready(LT + 500, "rand_ready");
      if ($urandom_range(0, 2) == 0) spurious_req = 1;
      issue(int'($urandom_range(0, 6)), int'($urandom_range(0, 140)), 0);
    end
    wait_ready(LT + 500, "rand_final_ready");

    // Illegal requests: err only, no DRP traffic, RST never raised
    d0 = den_cnt;
    r0 = rst_hi_cnt;
    issue(1, 0, 0);
    issue(1, 129, 0);
    issue(5, 10, 0);
    wait_ready(100, "illegal_ready");
    chk("illegal_no_den", 32'(den_cnt), 32'(d0));
    chk("illegal_no_rst", 32'(rst_hi_cnt), 32'(r0));

    // DRP timeout on RD2
    withhold_rd2 = 1;
    issue(4, 20, 1);
    wait_ready(1000, "drpto_ready");
    n = last_err_cyc - rd2_cyc;
    chk("drpto_latency_ok", 32'(n >= DT + 1 && n <= DT + 3), 32'd1);
    chk("drpto_rst_released", 32'(mmcm_rst), 32'd0);

    // Async reset during WR1, then init pass with LOCKED never arriving
    issue(1, 50, 2);
    n = 0;
    while (!(drp_den && drp_dwe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wr1_seen", 32'(drp_den && drp_dwe), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    lock_never = 1;
    exp_q.push_back(model_req(7, 0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    wait_ready(LT + 200, "lockto_ready");
    n = last_err_cyc - rel;
    chk("lockto_latency_ok", 32'(n >= LT + 1 && n <= LT + 3), 32'd1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
